// File: rtl/score_ctrl.sv
`default_nettype none
// score_ctrl: converts line-clear events to points, accumulates a saturating
// 4-digit BCD score and high score, and drives the digit/blank display stage.
module score_ctrl #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_add_valid,
  input  logic [2:0] i_add_lines,
  output logic       o_add_ready,
  input  logic       i_clear,
  input  logic       i_game_over,
  input  logic       i_show_high,
  output logic [3:0] o_disp_1,
  output logic [3:0] o_disp_2,
  output logic [3:0] o_disp_3,
  output logic [3:0] o_disp_4,
  output logic       o_disp_blank,
  output logic       o_busy
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] c_blink_last = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_score;
  logic [15:0] r_high;
  logic [15:0] r_work;
  logic [15:0] r_disp;
  logic        r_carry;
  logic [1:0]  r_idx;
  logic [3:0]  r_pts;
  logic [CW-1:0] r_blink_cnt;
  logic        r_phase;

  logic [3:0]  w_pts;
  logic [3:0]  w_dig;
  logic [3:0]  w_addend;
  logic [4:0]  w_sum;
  logic [15:0] w_commit;
  logic        w_accept;

  always_comb begin
    w_pts = 4'd0;
    case (i_add_lines)
      3'd1:    w_pts = 4'd1;
      3'd2:    w_pts = 4'd3;
      3'd3:    w_pts = 4'd5;
      3'd4:    w_pts = 4'd8;
      default: w_pts = 4'd0;
    endcase
  end

  assign w_dig    = r_work[{r_idx, 2'b00} +: 4];
  assign w_addend = (r_idx == 2'd0) ? r_pts : 4'd0;
  assign w_sum    = {1'b0, w_dig} + {1'b0, w_addend} + {4'd0, r_carry};
  // A carry out of the thousands digit means the true score exceeds 9999.
  assign w_commit = r_carry ? 16'h9999 : r_work;

  assign o_add_ready = (r_state == S_IDLE) & ~i_clear & ~i_game_over;
  assign w_accept    = i_add_valid & o_add_ready;
  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_score <= 16'h0000;
      r_high  <= 16'h0000;
      r_work  <= 16'h0000;
      r_carry <= 1'b0;
      r_idx   <= 2'd0;
      r_pts   <= 4'd0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_score <= 16'h0000;
      r_carry <= 1'b0;
      r_idx   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pts   <= w_pts;
            r_work  <= r_score;
            r_carry <= 1'b0;
            r_idx   <= 2'd0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          if (w_sum > 5'd9) begin
            r_work[{r_idx, 2'b00} +: 4] <= 4'(w_sum - 5'd10);
            r_carry <= 1'b1;
          end else begin
            r_work[{r_idx, 2'b00} +: 4] <= w_sum[3:0];
            r_carry <= 1'b0;
          end
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_FIN;
        end
        S_FIN: begin
          r_score <= w_commit;
          // Valid BCD orders the same as plain binary, digit 4 most significant.
          if (w_commit > r_high) r_high <= w_commit;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !i_game_over) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_disp <= 16'h0000;
    else     r_disp <= i_show_high ? r_high : r_score;
  end

  assign o_disp_1     = r_disp[3:0];
  assign o_disp_2     = r_disp[7:4];
  assign o_disp_3     = r_disp[11:8];
  assign o_disp_4     = r_disp[15:12];
  assign o_disp_blank = r_phase;

endmodule
`default_nettype wire
